load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_if.sv | 30 +++
 rtl/load_store_unit.sv | 147 ++++++++++++++
 tb/tb_load_store_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Pipeline request/response and memory-side signals of the load/store unit.
// The slave modport is the unit's view; the master modport is the pipeline/memory view.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] base;
  logic [15:0] offset;
  logic [31:0] store_data;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [7:0]  Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, base, offset, store_data, Read_data,
    output req_ready, resp_valid, resp_data, resp_err, MemRead, MemWrite, Address, Write_data
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, base, offset, store_data, Read_data,
    input  req_ready, resp_valid, resp_data, resp_err, MemRead, MemWrite, Address, Write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: word accesses, plus byte loads and
// read-modify-write byte stores when LSU_BYTE_ACCESS_EN is defined.
module load_store_unit (
  input  logic clk,
  input  logic rst_n,
  lsu_if.slave lsu
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] ea;
  logic        size_ok;
  logic        acc_err;
  logic        accept;
  logic        err_q;
  logic [7:0]  addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] load_val;

`ifdef LSU_BYTE_ACCESS_EN
  logic        write_q;
  logic        byte_q;
  logic        signed_q;
  logic [1:0]  lane_q;
  logic [7:0]  lane_byte;
  logic [31:0] merged;
`else
  logic        unused_signed;
  assign unused_signed = lsu.req_signed;
`endif

  assign ea     = lsu.base + {{16{lsu.offset[15]}}, lsu.offset};
  assign accept = lsu.req_valid && (state == IDLE);

  always_comb begin
    size_ok = (lsu.req_size == 2'b10);
`ifdef LSU_BYTE_ACCESS_EN
    if (lsu.req_size == 2'b00) size_ok = 1'b1;
`endif
    acc_err = (|ea[31:10]) || !size_ok ||
              ((lsu.req_size == 2'b10) && (ea[1:0] != 2'b00));
  end

  // Load result and store merge, both taken from the word on Read_data during RD.
  always_comb begin
`ifdef LSU_BYTE_ACCESS_EN
    lane_byte = lsu.Read_data[{lane_q, 3'b000} +: 8];
    merged    = lsu.Read_data;
    merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    if (!byte_q)
      load_val = lsu.Read_data;
    else if (signed_q)
      load_val = {{24{lane_byte[7]}}, lane_byte};
    else
      load_val = {24'h0, lane_byte};
`else
    load_val = lsu.Read_data;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (acc_err)
            state_nxt = RESP;
`ifdef LSU_BYTE_ACCESS_EN
          else if (lsu.req_write && (lsu.req_size == 2'b10))
`else
          else if (lsu.req_write)
`endif
            state_nxt = WR;
          else
            state_nxt = RD;
        end
      end
`ifdef LSU_BYTE_ACCESS_EN
      RD:      state_nxt = write_q ? WR : RESP;
`else
      RD:      state_nxt = RESP;
`endif
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset drops them immediately.
  always_comb begin
    lsu.req_ready  = (state == IDLE);
    lsu.resp_valid = (state == RESP);
    lsu.MemRead    = (state == RD);
    lsu.MemWrite   = (state == WR);
    lsu.resp_err   = (state == RESP) && err_q;
    lsu.resp_data  = (state == RESP) ? rdata_q : 32'h0;
    lsu.Address    = addr_q;
    lsu.Write_data = wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q    <= 1'b0;
      addr_q   <= 8'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
`ifdef LSU_BYTE_ACCESS_EN
      write_q  <= 1'b0;
      byte_q   <= 1'b0;
      signed_q <= 1'b0;
      lane_q   <= 2'b00;
`endif
    end else begin
      if (accept) begin
        err_q    <= acc_err;
        addr_q   <= ea[9:2];
        wdata_q  <= lsu.store_data;
        rdata_q  <= 32'h0;
`ifdef LSU_BYTE_ACCESS_EN
        write_q  <= lsu.req_write;
        byte_q   <= (lsu.req_size == 2'b00);
        signed_q <= lsu.req_signed;
        lane_q   <= ea[1:0];
`endif
      end
      if (state == RD) begin
`ifdef LSU_BYTE_ACCESS_EN
        if (write_q) wdata_q <= merged;
        else         rdata_q <= load_val;
`else
        rdata_q <= load_val;
`endif
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a behavioural access model predicts every
// cycle of each request, and literal pins anchor the model on known vectors.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_if bus ();
  load_store_unit dut (.clk(clk), .rst_n(rst_n), .lsu(bus));

`ifdef LSU_BYTE_ACCESS_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  // Memory device seen by the DUT, and the model's view of what it must hold.
  logic [31:0] mem     [256];
  logic [31:0] exp_mem [256];
  assign bus.Read_data = mem[bus.Address];
  always @(posedge clk) if (bus.MemWrite) mem[bus.Address] <= bus.Write_data;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-request expectations from the model, and what the DUT was seen doing.
  bit          active = 1'b0;
  bit          manual = 1'b0;
  int          cyc, exp_lat, obs_lat, obs_nstrobe;
  bit          exp_rd, exp_wr, exp_err;
  logic [7:0]  exp_addr, obs_addr;
  logic [31:0] exp_wdata, exp_rdata, obs_wdata, obs_rdata;
  logic        obs_err;

  task automatic predict(input bit w, input logic [1:0] sz, input bit sg,
                         input logic [31:0] b, input logic [15:0] o, input logic [31:0] d);
    int          off_i;
    int          idx, lane;
    logic [31:0] ea, word, bval;
    off_i    = $signed(o);
    ea       = b + off_i;
    idx      = (ea / 4) % 256;
    exp_addr = idx[7:0];
    exp_err  = (ea >= 32'h400) || !(sz == 2'd2 || (sz == 2'd0 && BYTE_EN)) ||
               (sz == 2'd2 && (ea % 4) != 0);
    exp_rd = 1'b0; exp_wr = 1'b0; exp_wdata = 32'h0; exp_rdata = 32'h0;
    if (exp_err) begin
      exp_lat = 1;
    end else if (sz == 2'd2) begin
      exp_lat = 2;
      if (w) begin
        exp_wr = 1'b1; exp_wdata = d; exp_mem[idx] = d;
      end else begin
        exp_rd = 1'b1; exp_rdata = exp_mem[idx];
      end
    end else begin
      lane = ea % 4;
      word = exp_mem[idx];
      bval = (word >> (8 * lane)) & 32'hFF;
      exp_rd = 1'b1;
      if (w) begin
        exp_lat = 3; exp_wr = 1'b1;
        exp_wdata = (word & ~(32'hFF << (8 * lane))) | ((d & 32'hFF) << (8 * lane));
        exp_mem[idx] = exp_wdata;
      end else begin
        exp_lat = 2;
        exp_rdata = (sg && bval >= 128) ? bval - 32'd256 : bval;
      end
    end
  endtask

  // Single compare process: every cycle out of reset is checked against the model.
  always @(negedge clk) begin
    if (rst_n && !manual) begin
      check("rd_wr_overlap", {31'h0, bus.MemRead & bus.MemWrite}, 32'h0);
      if (!active) begin
        check("idle_ready", {31'h0, bus.req_ready}, 32'h1);
        check("idle_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        check("idle_strobes", {30'h0, bus.MemRead, bus.MemWrite}, 32'h0);
      end else begin
        cyc++;
        check("req_ready", {31'h0, bus.req_ready}, {31'h0, cyc > exp_lat});
        check("resp_valid", {31'h0, bus.resp_valid}, {31'h0, cyc == exp_lat});
        check("MemRead", {31'h0, bus.MemRead}, {31'h0, exp_rd && cyc == 1});
        check("MemWrite", {31'h0, bus.MemWrite}, {31'h0, exp_wr && cyc == (exp_rd ? 2 : 1)});
        if (bus.MemRead || bus.MemWrite) begin
          obs_nstrobe++;
          obs_addr = bus.Address;
          check("Address", {24'h0, bus.Address}, {24'h0, exp_addr});
        end
        if (bus.MemWrite) begin
          obs_wdata = bus.Write_data;
          check("Write_data", bus.Write_data, exp_wdata);
        end
        if (bus.resp_valid) obs_lat = cyc;
        if (cyc == exp_lat) begin
          obs_rdata = bus.resp_data;
          obs_err   = bus.resp_err;
          check("resp_data", bus.resp_data, exp_rdata);
          check("resp_err", {31'h0, bus.resp_err}, {31'h0, exp_err});
        end else begin
          check("resp_err_quiet", {31'h0, bus.resp_err}, 32'h0);
        end
        if (cyc > exp_lat) active = 1'b0;
      end
    end
  end

  // Called at negedge+1; the request is offered for the very next edge.
  task automatic issue(input bit w, input logic [1:0] sz, input bit sg,
                       input logic [31:0] b, input logic [15:0] o, input logic [31:0] d,
                       input bit hammer);
    predict(w, sz, sg, b, o, d);
    obs_addr = 8'h0; obs_wdata = 32'hBAD0BAD0; obs_rdata = 32'hBAD0BAD0;
    obs_err = 1'bx; obs_lat = -1; obs_nstrobe = 0;
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz; bus.req_signed = sg;
    bus.base = b; bus.offset = o; bus.store_data = d;
    @(posedge clk); #1;
    cyc = 0; active = 1'b1;
    // Inputs need not hold; optionally keep a bogus request pending while busy.
    bus.base = $urandom; bus.offset = 16'($urandom); bus.store_data = $urandom;
    bus.req_write = ~w; bus.req_size = 2'b10; bus.req_valid = hammer;
    for (int i = 0; i < 8 && active; i++) begin
      @(negedge clk); #1;
      if (bus.resp_valid) bus.req_valid = 1'b0;
    end
    check("request_complete", {31'h0, active}, 32'h0);
    active = 1'b0;
    bus.req_valid = 1'b0;
  endtask

  task automatic pins(input string tag, input int lat, input logic err, input logic [31:0] rdata);
    check({tag, "_lat"}, obs_lat, lat);
    check({tag, "_err"}, {31'h0, obs_err}, {31'h0, err});
    check({tag, "_rdata"}, obs_rdata, rdata);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst_n = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b10; bus.req_signed = 1'b0;
    bus.base = 32'h0; bus.offset = 16'h0; bus.store_data = 32'h0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = (32'h01010101 * i) ^ 32'hA5A55A5A;
      exp_mem[i] = (32'h01010101 * i) ^ 32'hA5A55A5A;
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", {31'h0, bus.req_ready}, 32'h1);
    check("rst_outs", {29'h0, bus.resp_valid, bus.resp_err, bus.MemRead | bus.MemWrite}, 32'h0);
    check("rst_resp_data", bus.resp_data, 32'h0);
    check("rst_addr_wdata", {24'h0, bus.Address} | bus.Write_data, 32'h0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Word store / load at ea 0x104, first accept on the first edge out of reset.
    issue(1'b1, 2'd2, 1'b0, 32'h100, 16'h0004, 32'hDEADBEEF, 1'b1);
    check("ws_addr", {24'h0, obs_addr}, 32'h41);
    check("ws_wdata", obs_wdata, 32'hDEADBEEF);
    pins("ws", 2, 1'b0, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h100, 16'h0004, 32'h0, 1'b0);
    pins("wl", 2, 1'b0, 32'hDEADBEEF);

    // Faults: misaligned word, ea past 1 KiB via negative offset, illegal size.
    issue(1'b0, 2'd2, 1'b0, 32'h100, 16'h0002, 32'h0, 1'b0);
    pins("misalign", 1, 1'b1, 32'h0);
    check("misalign_strobes", obs_nstrobe, 0);
    issue(1'b0, 2'd2, 1'b0, 32'h404, 16'hFFFC, 32'h0, 1'b1);
    pins("range", 1, 1'b1, 32'h0);
    check("range_strobes", obs_nstrobe, 0);
    issue(1'b1, 2'd1, 1'b0, 32'h100, 16'h0004, 32'h77, 1'b0);
    pins("bad_size", 1, 1'b1, 32'h0);

    // Byte accesses on word 0xDEADBEEF (faults when byte support is absent).
    issue(1'b0, 2'd0, 1'b1, 32'h100, 16'h0007, 32'h0, 1'b0);
    pins("lb_s", BYTE_EN ? 2 : 1, !BYTE_EN, BYTE_EN ? 32'hFFFFFFDE : 32'h0);
    issue(1'b0, 2'd0, 1'b0, 32'h100, 16'h0007, 32'h0, 1'b0);
    pins("lb_u", BYTE_EN ? 2 : 1, !BYTE_EN, BYTE_EN ? 32'h000000DE : 32'h0);
    issue(1'b1, 2'd0, 1'b0, 32'h100, 16'h0005, 32'h00000055, 1'b1);
    pins("sb", BYTE_EN ? 3 : 1, !BYTE_EN, 32'h0);
    check("sb_wdata", obs_wdata, BYTE_EN ? 32'hDEAD55EF : 32'hBAD0BAD0);

    // Address wrap mod 2^32 and the top legal word.
    issue(1'b1, 2'd2, 1'b0, 32'h00000010, 16'hFFF0, 32'h12345678, 1'b0);
    check("wrap_addr", {24'h0, obs_addr}, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'hFFFFFFF0, 16'h0010, 32'h0, 1'b0);
    pins("wrap_load", 2, 1'b0, 32'h12345678);
    issue(1'b1, 2'd2, 1'b0, 32'h3F0, 16'h000C, 32'hCAFEF00D, 1'b1);
    check("top_addr", {24'h0, obs_addr}, 32'hFF);
    issue(1'b0, 2'd2, 1'b0, 32'h3FC, 16'h0000, 32'h0, 1'b0);
    pins("top_load", 2, 1'b0, 32'hCAFEF00D);

    // Reset during the write strobe aborts the store and produces no response.
    manual = 1'b1;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_signed = 1'b0;
    bus.req_size = BYTE_EN ? 2'd0 : 2'd2; bus.base = 32'h100;
    bus.offset = BYTE_EN ? 16'h0005 : 16'h0004; bus.store_data = 32'h11223344;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk); #1;
      if (bus.MemWrite) seen = 1'b1;
    end
    check("abort_reached_wr", {31'h0, seen}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_strobes", {30'h0, bus.MemRead, bus.MemWrite}, 32'h0);
    check("abort_ready", {31'h0, bus.req_ready}, 32'h1);
    check("abort_resp", {30'h0, bus.resp_valid, bus.resp_err}, 32'h0);
    check("abort_addr_wdata", {24'h0, bus.Address} | bus.Write_data | bus.resp_data, 32'h0);
    @(posedge clk); #1;
    check("abort_mem_untouched", mem[8'h41], exp_mem[8'h41]);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("post_abort_no_resp", {31'h0, bus.resp_valid}, 32'h0);
      check("post_abort_ready", {31'h0, bus.req_ready}, 32'h1);
    end
    manual = 1'b0;

    issue(1'b0, 2'd2, 1'b0, 32'h104, 16'h0000, 32'h0, 1'b0);
    pins("after_abort", 2, 1'b0, BYTE_EN ? 32'hDEAD55EF : 32'hDEADBEEF);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
